// File: rtl/wash_program_sequencer.sv
// ---------------------------------------------------------------------------
// wash_program_sequencer
//
// Purpose:
//   Runs one complete wash program. The main pass is fill -> wash -> drain ->
//   spin. RINSE_CNT rinse passes follow, each fill -> rinse -> drain -> spin.
//   A timed done-beep ends the program. Phase durations are counted in
//   `tick` enables, and the whole block runs on the system clock.
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   tick                one-cycle time-base enable
//   start, stop, pause  one-cycle command pulses (pause toggles pause/resume)
//   waterfull           level, drum full
//   state_code [2:0]    0 IDLE 1 FILL 2 WASH 3 DRAIN 4 SPIN 5 PAUSE 6 DONE 7 ALARM
//   remain [7:0]        ticks left in the current phase
//   pass_num [1:0]      0 = main wash, n = rinse n
//   valve_in, motor_wash, valve_out, motor_spin, buzzer   actuator enables
//   busy                high in every state except IDLE
//
// Command inputs are single-cycle pulses. There is no handshake: each pulse
// is acted on in the cycle it is seen, or dropped if the current state
// ignores it. Every output is a flop, so no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module wash_program_sequencer #(
    parameter int FILL_TO   = 20,
    parameter int WASH_T    = 10,
    parameter int RINSE_T   = 5,
    parameter int DRAIN_T   = 4,
    parameter int SPIN_T    = 6,
    parameter int DONE_T    = 3,
    parameter int RINSE_CNT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       waterfull,
    output logic [2:0] state_code,
    output logic [7:0] remain,
    output logic [1:0] pass_num,
    output logic       valve_in,
    output logic       motor_wash,
    output logic       valve_out,
    output logic       motor_spin,
    output logic       buzzer,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_SPIN  = 3'd4,
        ST_PAUSE = 3'd5,
        ST_DONE  = 3'd6,
        ST_ALARM = 3'd7
    } state_t;

    localparam logic [7:0] FILL_LD   = 8'(FILL_TO);
    localparam logic [7:0] WASH_LD   = 8'(WASH_T);
    localparam logic [7:0] RINSE_LD  = 8'(RINSE_T);
    localparam logic [7:0] DRAIN_LD  = 8'(DRAIN_T);
    localparam logic [7:0] SPIN_LD   = 8'(SPIN_T);
    localparam logic [7:0] DONE_LD   = 8'(DONE_T);
    localparam logic [1:0] LAST_PASS = 2'(RINSE_CNT);

    state_t     state_q, state_d;
    state_t     saved_q, saved_d;     // phase to resume when leaving PAUSE
    logic [7:0] remain_q, remain_d;
    logic [1:0] pass_q, pass_d;
    logic       buzzer_d;
    logic       phase_end;

    // The tick that would take remain from 1 to 0 loads the next phase
    // instead. This is why remain never reads 0 inside a timed phase.
    assign phase_end = tick && (remain_q == 8'd1);

    // The state register is exposed directly as the debug/display state code.
    assign state_code = state_q;
    assign remain     = remain_q;
    assign pass_num   = pass_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            saved_q    <= ST_IDLE;
            remain_q   <= 8'd0;
            pass_q     <= 2'd0;
            valve_in   <= 1'b0;
            motor_wash <= 1'b0;
            valve_out  <= 1'b0;
            motor_spin <= 1'b0;
            buzzer     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            saved_q    <= saved_d;
            remain_q   <= remain_d;
            pass_q     <= pass_d;
            // Actuators decode the next state, so they change on the same
            // edge as state_code.
            valve_in   <= (state_d == ST_FILL);
            motor_wash <= (state_d == ST_WASH);
            valve_out  <= (state_d == ST_DRAIN);
            motor_spin <= (state_d == ST_SPIN);
            buzzer     <= buzzer_d;
            busy       <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        remain_d = remain_q;
        pass_d   = pass_q;
        buzzer_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FILL;
                    remain_d = FILL_LD;
                    pass_d   = 2'd0;
                end
            end

            ST_FILL, ST_WASH, ST_DRAIN, ST_SPIN: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    saved_d  = ST_IDLE;
                    remain_d = 8'd0;
                    pass_d   = 2'd0;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                    saved_d = state_q;
                end else if ((state_q == ST_FILL) && waterfull) begin
                    // A full drum beats a coincident timeout tick.
                    state_d  = ST_WASH;
                    remain_d = (pass_q == 2'd0) ? WASH_LD : RINSE_LD;
                end else if (phase_end) begin
                    case (state_q)
                        ST_FILL: begin
                            state_d  = ST_ALARM;
                            remain_d = 8'd0;
                        end
                        ST_WASH: begin
                            state_d  = ST_DRAIN;
                            remain_d = DRAIN_LD;
                        end
                        ST_DRAIN: begin
                            state_d  = ST_SPIN;
                            remain_d = SPIN_LD;
                        end
                        default: begin
                            // End of SPIN: either the last pass is finished
                            // or the next rinse pass starts with a refill.
                            if (pass_q == LAST_PASS) begin
                                state_d  = ST_DONE;
                                remain_d = DONE_LD;
                            end else begin
                                state_d  = ST_FILL;
                                remain_d = FILL_LD;
                                pass_d   = pass_q + 2'd1;
                            end
                        end
                    endcase
                end else if (tick) begin
                    remain_d = remain_q - 8'd1;
                end
            end

            ST_PAUSE: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    saved_d  = ST_IDLE;
                    remain_d = 8'd0;
                    pass_d   = 2'd0;
                end else if (pause || start) begin
                    state_d = saved_q;
                end
            end

            ST_DONE: begin
                if (stop || phase_end) begin
                    state_d  = ST_IDLE;
                    saved_d  = ST_IDLE;
                    remain_d = 8'd0;
                    pass_d   = 2'd0;
                end else if (tick) begin
                    remain_d = remain_q - 8'd1;
                end
            end

            default: begin
                // ALARM holds until stop or reset.
                if (stop) begin
                    state_d  = ST_IDLE;
                    saved_d  = ST_IDLE;
                    remain_d = 8'd0;
                    pass_d   = 2'd0;
                end
            end
        endcase

        // The buzzer is steady in DONE. In ALARM it starts low on entry and
        // then toggles on each tick.
        if (state_d == ST_DONE) begin
            buzzer_d = 1'b1;
        end else if ((state_d == ST_ALARM) && (state_q == ST_ALARM)) begin
            buzzer_d = buzzer ^ tick;
        end
    end

endmodule

// File: tb/tb_wash_program_sequencer.sv
module tb_wash_program_sequencer;

  localparam int FILL_TO   = 20;
  localparam int WASH_T    = 10;
  localparam int RINSE_T   = 5;
  localparam int DRAIN_T   = 4;
  localparam int SPIN_T    = 6;
  localparam int DONE_T    = 3;
  localparam int RINSE_CNT = 1;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       waterfull = 1'b0;
  logic [2:0] state_code;
  logic [7:0] remain;
  logic [1:0] pass_num;
  logic       valve_in, motor_wash, valve_out, motor_spin, buzzer, busy;

  always #5 clk = ~clk;

  wash_program_sequencer #(
    .FILL_TO(FILL_TO), .WASH_T(WASH_T), .RINSE_T(RINSE_T), .DRAIN_T(DRAIN_T),
    .SPIN_T(SPIN_T), .DONE_T(DONE_T), .RINSE_CNT(RINSE_CNT)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .pause(pause), .waterfull(waterfull), .state_code(state_code),
    .remain(remain), .pass_num(pass_num), .valve_in(valve_in),
    .motor_wash(motor_wash), .valve_out(valve_out), .motor_spin(motor_spin),
    .buzzer(buzzer), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The program is a flat list of phases (code, duration, pass). The model
  // walks an index through that list, with flags for idle/pause/alarm.
  int prog_code[$];
  int prog_dur[$];
  int prog_pass[$];
  bit m_idle = 1'b1;
  bit m_paused = 1'b0;
  bit m_alarm = 1'b0;
  bit m_buz = 1'b0;
  int m_idx = 0;
  int m_remain = 0;

  function automatic void build_program();
    for (int p = 0; p <= RINSE_CNT; p++) begin
      prog_code.push_back(1); prog_dur.push_back(FILL_TO);                   prog_pass.push_back(p);
      prog_code.push_back(2); prog_dur.push_back(p == 0 ? WASH_T : RINSE_T); prog_pass.push_back(p);
      prog_code.push_back(3); prog_dur.push_back(DRAIN_T);                   prog_pass.push_back(p);
      prog_code.push_back(4); prog_dur.push_back(SPIN_T);                    prog_pass.push_back(p);
    end
    prog_code.push_back(6); prog_dur.push_back(DONE_T); prog_pass.push_back(RINSE_CNT);
  endfunction

  function automatic void model_reset();
    m_idle = 1'b1; m_paused = 1'b0; m_alarm = 1'b0; m_buz = 1'b0;
    m_idx = 0; m_remain = 0;
  endfunction

  function automatic void model_step(input bit st, input bit sp, input bit pa,
                                     input bit wf, input bit tk);
    int code;
    if (m_idle) begin
      if (st) begin
        m_idle = 1'b0; m_idx = 0; m_remain = prog_dur[0];
      end
      return;
    end
    if (sp) begin
      model_reset();
      return;
    end
    if (m_alarm) begin
      if (tk) m_buz = !m_buz;
      return;
    end
    if (m_paused) begin
      if (pa || st) m_paused = 1'b0;
      return;
    end
    code = prog_code[m_idx];
    if (pa && code != 6) begin
      m_paused = 1'b1;
      return;
    end
    if (code == 1 && wf) begin
      m_idx++;
      m_remain = prog_dur[m_idx];
      return;
    end
    if (tk) begin
      if (m_remain > 1) begin
        m_remain--;
      end else if (code == 1) begin
        m_alarm = 1'b1; m_buz = 1'b0;
      end else begin
        m_idx++;
        if (m_idx == prog_code.size()) model_reset();
        else m_remain = prog_dur[m_idx];
      end
    end
  endfunction

  function automatic int e_code();
    if (m_idle) return 0;
    if (m_alarm) return 7;
    if (m_paused) return 5;
    return prog_code[m_idx];
  endfunction

  function automatic int e_act();
    case (e_code())
      1: return 5'b10000;
      2: return 5'b01000;
      3: return 5'b00100;
      4: return 5'b00010;
      6: return 5'b00001;
      7: return {4'b0000, m_buz};
      default: return 5'b00000;
    endcase
  endfunction

  task automatic check_model();
    check("model.state_code", state_code, e_code());
    check("model.remain", remain, (m_idle || m_alarm) ? 0 : m_remain);
    check("model.pass_num", pass_num, m_idle ? 0 : prog_pass[m_idx]);
    check("model.actuators", {valve_in, motor_wash, valve_out, motor_spin, buzzer}, e_act());
    check("model.busy", busy, e_code() != 0);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit rs, input bit st, input bit sp, input bit pa,
                       input bit wf, input bit tk);
    @(negedge clk);
    reset = rs; start = st; stop = sp; pause = pa; waterfull = wf; tick = tk;
    if (rs) model_reset();
    else model_step(st, sp, pa, wf, tk);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rs, st, sp, pa, wf, tk;
    int code, rem, pass;
    int act;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit rs, input bit st, input bit sp, input bit pa,
                              input bit wf, input bit tk, input int code,
                              input int rem, input int pass, input int act);
    vec_t v;
    v.rs = rs; v.st = st; v.sp = sp; v.pa = pa; v.wf = wf; v.tk = tk;
    v.code = code; v.rem = rem; v.pass = pass; v.act = act;
    return v;
  endfunction

  // ---------------- multi-cycle sequences ----------------
  task automatic full_program();
    int codes[$];
    int rems[$];
    int exp_codes[10] = '{1, 2, 3, 4, 1, 2, 3, 4, 6, 0};
    int exp_rems[10]  = '{20, 10, 4, 6, 20, 5, 4, 6, 3, 0};
    int fill_ticks = 0;
    int buz_ticks = 0;
    int cyc = 0;
    logic [2:0] prev;
    bit tk, wf;
    cycle(0, 1, 0, 0, 0, 0);
    codes.push_back(state_code); rems.push_back(remain);
    prev = state_code;
    while (state_code != 3'd0 && cyc < 2000) begin
      tk = (cyc % 2) == 1;
      wf = (state_code == 3'd1) && (fill_ticks >= 5);
      if (state_code == 3'd1 && tk && !wf) fill_ticks++;
      if (tk && buzzer) buz_ticks++;
      cycle(0, 0, 0, 0, wf, tk);
      cyc++;
      if (state_code != prev) begin
        codes.push_back(state_code); rems.push_back(remain);
        if (state_code == 3'd1) fill_ticks = 0;
        prev = state_code;
      end
    end
    check("full.terminated", cyc < 2000, 1);
    check("full.phase_count", codes.size(), 10);
    for (int i = 0; i < 10 && i < codes.size(); i++) begin
      check("full.phase_code", codes[i], exp_codes[i]);
      check("full.phase_remain", rems[i], exp_rems[i]);
    end
    check("full.done_buzz_ticks", buz_ticks, DONE_T);
    check("full.busy_dropped", busy, 0);
  endtask

  task automatic alarm_seq();
    cycle(0, 1, 0, 0, 0, 0);
    ticks(FILL_TO - 1);
    check("alarm.pre_state", state_code, 1);
    check("alarm.pre_remain", remain, 1);
    ticks(1);
    check("alarm.state", state_code, 7);
    check("alarm.remain", remain, 0);
    check("alarm.buzz0", buzzer, 0);
    ticks(1);
    check("alarm.buzz1", buzzer, 1);
    ticks(1);
    check("alarm.buzz2", buzzer, 0);
    cycle(0, 1, 0, 1, 0, 0);
    check("alarm.ignore_start_pause", state_code, 7);
    cycle(0, 0, 1, 0, 0, 0);
    check("alarm.stop", state_code, 0);
  endtask

  task automatic coincide_pause_seq();
    cycle(0, 1, 0, 0, 0, 0);
    ticks(FILL_TO - 1);
    cycle(0, 0, 0, 0, 1, 1);
    check("coincide.state", state_code, 2);
    check("coincide.remain", remain, WASH_T);
    ticks(3);
    check("pause.pre_remain", remain, 7);
    cycle(0, 0, 0, 1, 0, 1);
    check("pause.state", state_code, 5);
    check("pause.remain", remain, 7);
    ticks(5);
    check("pause.hold_remain", remain, 7);
    check("pause.actuators", {valve_in, motor_wash, valve_out, motor_spin, buzzer}, 0);
    cycle(0, 1, 0, 0, 0, 0);
    check("resume.state", state_code, 2);
    check("resume.remain", remain, 7);
    check("resume.motor_wash", motor_wash, 1);
    ticks(7);
    check("drain.state", state_code, 3);
    cycle(0, 1, 0, 0, 0, 0);
    check("drain.start_ignored_state", state_code, 3);
    check("drain.start_ignored_remain", remain, DRAIN_T);
    ticks(DRAIN_T + SPIN_T);
    check("rinse.state", state_code, 1);
    check("rinse.pass", pass_num, 1);
    cycle(0, 0, 0, 1, 0, 0);
    check("rinse.paused", state_code, 5);
    cycle(0, 0, 1, 0, 0, 0);
    check("stop_pause.state", state_code, 0);
    check("stop_pause.pass", pass_num, 0);
    cycle(0, 0, 0, 1, 0, 0);
    check("stop_pause.pause_in_idle", state_code, 0);
    cycle(0, 1, 0, 0, 0, 0);
    check("restart.state", state_code, 1);
    check("restart.pass", pass_num, 0);
    check("restart.remain", remain, FILL_TO);
  endtask

  task automatic reset_spin_seq();
    // Entered from FILL pass 0 with remain = FILL_TO.
    cycle(0, 0, 0, 0, 1, 0);
    ticks(WASH_T + DRAIN_T + 3);
    check("rst_spin.pre_state", state_code, 4);
    check("rst_spin.pre_remain", remain, 3);
    cycle(1, 0, 0, 0, 0, 1);
    check("rst_spin.state", state_code, 0);
    check("rst_spin.remain", remain, 0);
    check("rst_spin.pass", pass_num, 0);
    check("rst_spin.actuators", {valve_in, motor_wash, valve_out, motor_spin, buzzer}, 0);
    cycle(0, 1, 0, 0, 0, 0);
    check("rst_spin.restart_state", state_code, 1);
    check("rst_spin.restart_remain", remain, FILL_TO);
  endtask

  // ---------------- main ----------------
  initial begin
    build_program();

    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 5'b00000));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 5'b00000));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 5'b00000));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 20, 0, 5'b10000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 19, 0, 5'b10000));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 19, 0, 5'b10000));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2, 10, 0, 5'b01000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2,  9, 0, 5'b01000));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 5,  9, 0, 5'b00000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 5,  9, 0, 5'b00000));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 5,  9, 0, 5'b00000));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 2,  9, 0, 5'b01000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2,  8, 0, 5'b01000));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 5,  8, 0, 5'b00000));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 5'b00000));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 20, 0, 5'b10000));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2, 10, 0, 5'b01000));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,  0, 0, 5'b00000));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rs, vecs[i].st, vecs[i].sp, vecs[i].pa, vecs[i].wf, vecs[i].tk);
      check($sformatf("vec%0d.state", i), state_code, vecs[i].code);
      check($sformatf("vec%0d.remain", i), remain, vecs[i].rem);
      check($sformatf("vec%0d.pass", i), pass_num, vecs[i].pass);
      check($sformatf("vec%0d.act", i),
            {valve_in, motor_wash, valve_out, motor_spin, buzzer}, vecs[i].act);
      check($sformatf("vec%0d.busy", i), busy, vecs[i].code != 0);
    end

    full_program();
    alarm_seq();
    coincide_pause_seq();
    reset_spin_seq();

    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      int wf_div;
      wf_div = (i < 2000) ? 5 : 59;
      cycle($urandom_range(0, 599) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 149) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, wf_div) == 0, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
